// File: rtl/alu32_serial_seq.sv
// Bit-serial ALU: one bit-slice per clock, LSB first, with a 1-bit carry between slices.
// Operands are latched on start; result and flags are registered on the FIN edge.
module alu32_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cin_msb_q, cout_msb_q, sum_msb_q;
  logic             cout_q, overflow_q, zero_q, busy_q, done_q;

  logic             ax, bx, sum, carry_d, bit_d;
  logic             arith, ovf_raw, cout_d, overflow_d, zero_d;
  logic [WIDTH-1:0] result_d;

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // One slice: operand bits shift out of a_q/b_q at bit 0
  always_comb begin
    ax = a_q[0];
    bx = b_q[0];
    case (op_q)
      OP_SUB, OP_SLT: bx = ~b_q[0];
      OP_NOR: begin
        ax = ~a_q[0];
        bx = ~b_q[0];
      end
      default: ;
    endcase
    sum     = ax ^ bx ^ carry_q;
    carry_d = (ax & bx) | (carry_q & (ax ^ bx));
    case (op_q)
      OP_AND, OP_NOR:         bit_d = ax & bx;
      OP_OR:                  bit_d = ax | bx;
      OP_XOR:                 bit_d = ax ^ bx;
      OP_ADD, OP_SUB, OP_SLT: bit_d = sum;
      default:                bit_d = 1'b0;
    endcase
  end

  always_comb begin
    arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
    ovf_raw    = cin_msb_q ^ cout_msb_q;
    overflow_d = arith & ovf_raw;
    cout_d     = arith & cout_msb_q;
    result_d   = acc_q;
    if (op_q == OP_SLT) begin
      result_d    = '0;
      result_d[0] = sum_msb_q ^ ovf_raw;
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      acc_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      sum_msb_q  <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= (op == OP_SUB) || (op == OP_SLT);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= {bit_d, acc_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            cin_msb_q  <= carry_q;
            cout_msb_q <= carry_d;
            sum_msb_q  <= sum;
            state_q    <= FIN;
          end
        end
        FIN: begin
          result_q   <= result_d;
          cout_q     <= cout_d;
          overflow_q <= overflow_d;
          zero_q     <= zero_d;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
